// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch sequencing controller: datapath widths,
// control-flow opcode encodings, the controller state type and an
// immediate sign-extension helper.
package definitions;

  localparam int DATA_WIDTH   = 8;
  localparam int INSN_WIDTH   = 9;
  localparam logic [DATA_WIDTH-1:0] START_ADDRESS = '0;

  localparam int OPCODE_WIDTH = 3;
  localparam int IMM_WIDTH    = INSN_WIDTH - OPCODE_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_BRC = 3'b101;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'b110;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_HALTED = 3'd4
  } fetchState_t;

  // Widen the instruction immediate to a full data word, keeping its sign so
  // that negative branch offsets wrap the PC backwards.
  function automatic logic [DATA_WIDTH-1:0] signExtendImm(input logic [IMM_WIDTH-1:0] imm);
    return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_control_counter.sv
// Saturating event counter: counts up on i_inc and sticks at all-ones.
// Used for the optional retired/flush statistics of fetch_control.
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_CLK,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count qualified events, holding at the maximum instead of wrapping.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_control.sv
// Fetch sequencing and redirect controller. Drives the fetch unit's control
// inputs, decodes branch/jump/halt opcodes from the registered fetch output,
// issues redirects combinationally in the decode cycle and squashes the one
// stale word fetch delivers afterwards.
// Optional statistics counters are built when FETCH_CONTROL_STATS_EN is defined.
module fetch_control
  import definitions::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_condition,
  input  logic [DATA_WIDTH-1:0]  i_jumpTarget,
  input  logic [INSN_WIDTH-1:0]  i_instruction,
  output logic                   o_fetchRun,
  output logic                   o_fetchReset,
  output logic                   o_fetchHalt,
  output logic                   o_fetchBranchJump,
  output logic                   o_fetchRelative,
  output logic [DATA_WIDTH-1:0]  o_fetchDest,
  output logic                   o_insnValid,
  output logic                   o_halted
`ifdef FETCH_CONTROL_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_retiredCount,
  output logic [COUNT_WIDTH-1:0] o_flushCount
`endif
);

  fetchState_t                 r_state;
  fetchState_t                 w_nextState;
  logic [OPCODE_WIDTH-1:0]     w_opcode;
  logic [DATA_WIDTH-1:0]       w_imm;

  assign w_opcode = i_instruction[INSN_WIDTH-1 -: OPCODE_WIDTH];
  assign w_imm    = signExtendImm(i_instruction[IMM_WIDTH-1:0]);

  // State register; reset wins over everything and discards any pending flush or stall.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Decode and fetch-control outputs. Within RUN the priority is
  // stall, then halt, then jump/taken branch, then plain pass-through.
  always_comb begin
    w_nextState       = r_state;
    o_fetchRun        = 1'b0;
    o_fetchReset      = 1'b0;
    o_fetchHalt       = 1'b0;
    o_fetchBranchJump = 1'b0;
    o_fetchRelative   = 1'b0;
    o_fetchDest       = '0;
    o_insnValid       = 1'b0;
    o_halted          = 1'b0;
    if (i_reset) begin
      o_fetchReset = 1'b1;
      w_nextState  = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            o_fetchRun  = 1'b1;
            w_nextState = ST_PRIME;
          end else begin
            o_fetchReset = 1'b1;
          end
        end
        ST_PRIME: begin
          o_fetchRun  = 1'b1;
          w_nextState = ST_RUN;
        end
        ST_RUN: begin
          o_insnValid = 1'b1;
          if (i_stall) begin
            o_fetchHalt = 1'b1;
          end else if (w_opcode == OP_HLT) begin
            o_fetchHalt = 1'b1;
            w_nextState = ST_HALTED;
          end else if (w_opcode == OP_JMP) begin
            o_fetchRun        = 1'b1;
            o_fetchBranchJump = 1'b1;
            o_fetchDest       = i_jumpTarget;
            w_nextState       = ST_FLUSH;
          end else if ((w_opcode == OP_BRC) && i_condition) begin
            o_fetchRun        = 1'b1;
            o_fetchBranchJump = 1'b1;
            o_fetchRelative   = 1'b1;
            o_fetchDest       = w_imm;
            w_nextState       = ST_FLUSH;
          end else begin
            o_fetchRun = 1'b1;
          end
        end
        ST_FLUSH: begin
          o_fetchRun  = 1'b1;
          w_nextState = ST_RUN;
        end
        ST_HALTED: begin
          o_fetchHalt = 1'b1;
          o_halted    = 1'b1;
        end
        default: begin
          o_fetchReset = 1'b1;
          w_nextState  = ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_CONTROL_STATS_EN
  logic                   w_retireEvent;
  logic                   w_flushEvent;
  logic [COUNT_WIDTH-1:0] w_retiredCount;
  logic [COUNT_WIDTH-1:0] w_flushCount;

  assign w_retireEvent = o_insnValid && !i_stall;
  assign w_flushEvent  = (r_state == ST_RUN) && (w_nextState == ST_FLUSH);

  saturating_counter #(.WIDTH(COUNT_WIDTH)) u_retiredCounter (
    .i_CLK   (i_CLK),
    .i_reset (i_reset),
    .i_inc   (w_retireEvent),
    .o_count (w_retiredCount)
  );

  saturating_counter #(.WIDTH(COUNT_WIDTH)) u_flushCounter (
    .i_CLK   (i_CLK),
    .i_reset (i_reset),
    .i_inc   (w_flushEvent),
    .o_count (w_flushCount)
  );

  // Counters read as zero for the whole time reset is held, not just after the edge.
  assign o_retiredCount = i_reset ? '0 : w_retiredCount;
  assign o_flushCount   = i_reset ? '0 : w_flushCount;
`else
  logic [COUNT_WIDTH-1:0] w_unusedCountWidth;
  assign w_unusedCountWidth = '0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control. A small behavioural fetch unit (PC plus
// registered instruction word) follows the controller's outputs, so redirect
// targets show up as the instruction words that reach the decode slot.
// Stimulus pushes hand-computed expected outputs per cycle; a monitor pops
// and compares them on the falling edge.
module tb_fetch_control;
  import definitions::*;

  localparam logic [6:0] F_RUN    = 7'b1000000;
  localparam logic [6:0] F_RST    = 7'b0100000;
  localparam logic [6:0] F_HALT   = 7'b0010000;
  localparam logic [6:0] F_BJ     = 7'b0001000;
  localparam logic [6:0] F_REL    = 7'b0000100;
  localparam logic [6:0] F_VALID  = 7'b0000010;
  localparam logic [6:0] F_HALTED = 7'b0000001;

  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [7:0]  dest;
    logic [8:0]  insn;
    logic        chkCnt;
    int unsigned ret;
    int unsigned flu;
  } exp_t;

  logic       i_CLK = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stall = 1'b0;
  logic       i_condition = 1'b0;
  logic [7:0] i_jumpTarget;
  logic [8:0] i_instruction = 9'h000;
  logic       o_fetchRun, o_fetchReset, o_fetchHalt, o_fetchBranchJump, o_fetchRelative;
  logic [7:0] o_fetchDest;
  logic       o_insnValid, o_halted;
`ifdef FETCH_CONTROL_STATS_EN
  logic [15:0] o_retiredCount, o_flushCount;
`endif

  logic [8:0] mem [256];
  logic [7:0] jt  [256];
  logic [7:0] pc = 8'h00;
  logic [7:0] insnAddr = 8'h00;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  fetch_control #(.COUNT_WIDTH(16)) dut (
    .i_CLK             (i_CLK),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_stall           (i_stall),
    .i_condition       (i_condition),
    .i_jumpTarget      (i_jumpTarget),
    .i_instruction     (i_instruction),
    .o_fetchRun        (o_fetchRun),
    .o_fetchReset      (o_fetchReset),
    .o_fetchHalt       (o_fetchHalt),
    .o_fetchBranchJump (o_fetchBranchJump),
    .o_fetchRelative   (o_fetchRelative),
    .o_fetchDest       (o_fetchDest),
    .o_insnValid       (o_insnValid),
    .o_halted          (o_halted)
`ifdef FETCH_CONTROL_STATS_EN
    ,
    .o_retiredCount    (o_retiredCount),
    .o_flushCount      (o_flushCount)
`endif
  );

  // 10 time-unit clock.
  always #5 i_CLK = ~i_CLK;

  // The jump target register value belongs to whichever word is in the decode slot.
  assign i_jumpTarget = jt[insnAddr];

  // Behavioural fetch unit: redirect loads the PC while the stale PC word is still delivered.
  always @(posedge i_CLK) begin
    if (o_fetchReset) begin
      pc            <= 8'h00;
      insnAddr      <= 8'h00;
      i_instruction <= 9'h000;
    end else if (o_fetchBranchJump) begin
      pc            <= o_fetchRelative ? (pc + o_fetchDest) : o_fetchDest;
      insnAddr      <= pc;
      i_instruction <= mem[pc];
    end else if (o_fetchRun) begin
      pc            <= pc + 8'h01;
      insnAddr      <= pc;
      i_instruction <= mem[pc];
    end
  end

  // Drive one cycle of inputs just after the edge and queue what that cycle should show.
  task automatic applyStimulus(input string name, input logic rst, input logic start,
                               input logic stall, input logic cond, input logic [6:0] flags,
                               input logic [7:0] dest, input logic [8:0] insn,
                               input logic chk, input int unsigned ret, input int unsigned flu);
    exp_t e;
    @(posedge i_CLK);
    #1;
    i_reset     = rst;
    i_start     = start;
    i_stall     = stall;
    i_condition = cond;
    e.name = name; e.flags = flags; e.dest = dest; e.insn = insn;
    e.chkCnt = chk; e.ret = ret; e.flu = flu;
    expQ.push_back(e);
  endtask

  // Compare the observed outputs of one cycle against its queued expectation.
  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    act = {o_fetchRun, o_fetchReset, o_fetchHalt, o_fetchBranchJump,
           o_fetchRelative, o_insnValid, o_halted};
    checkCount++;
    if (act === e.flags && o_fetchDest === e.dest && i_instruction === e.insn)
      passCount++;
    else
      $display("[TB] FAIL %s: got flags=%b dest=%h insn=%h, expected flags=%b dest=%h insn=%h",
               e.name, act, o_fetchDest, i_instruction, e.flags, e.dest, e.insn);
`ifdef FETCH_CONTROL_STATS_EN
    if (e.chkCnt) begin
      checkCount++;
      if (o_retiredCount == 16'(e.ret) && o_flushCount == 16'(e.flu))
        passCount++;
      else
        $display("[TB] FAIL %s_counters: got retired=%0d flush=%0d, expected retired=%0d flush=%0d",
                 e.name, o_retiredCount, o_flushCount, e.ret, e.flu);
    end
`endif
  endtask

  // Monitor: consume expectations on the falling edge, away from state updates.
  always @(negedge i_CLK) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Program image and directed sequence. NOP words carry their address in the immediate.
  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = {3'b000, 6'(a & 63)};
      jt[a]  = 8'hA5;
    end
    mem[8'h00] = 9'h180; jt[8'h00] = 8'h20;
    mem[8'h02] = 9'h180; jt[8'h02] = 8'h10;
    mem[8'h03] = 9'h180; jt[8'h03] = 8'h40;
    mem[8'h0F] = 9'h145;
    mem[8'h10] = 9'h17E;
    mem[8'h11] = 9'h180; jt[8'h11] = 8'hFF;
    mem[8'hFF] = 9'h180; jt[8'hFF] = 8'h00;
    mem[8'h20] = 9'h1C0;

    //              name            rst st sl cd flags                      dest   insn    chk ret flu
    applyStimulus("reset0",        1, 0, 0, 0, F_RST,                     8'h00, 9'h000, 1, 0, 0);
    applyStimulus("reset1",        1, 1, 0, 0, F_RST,                     8'h00, 9'h000, 0, 0, 0);
    applyStimulus("idle",          0, 0, 0, 0, F_RST,                     8'h00, 9'h000, 0, 0, 0);
    applyStimulus("start",         0, 1, 0, 0, F_RUN,                     8'h00, 9'h000, 0, 0, 0);
    applyStimulus("prime",         0, 0, 0, 0, F_RUN,                     8'h00, 9'h180, 0, 0, 0);
    applyStimulus("run_first",     0, 1, 0, 0, F_RUN|F_VALID,             8'h00, 9'h001, 0, 0, 0);
    applyStimulus("jmp_0x02",      0, 0, 0, 0, F_RUN|F_VALID|F_BJ,        8'h10, 9'h180, 0, 0, 0);
    applyStimulus("flush_jmp",     0, 0, 0, 0, F_RUN,                     8'h00, 9'h180, 0, 0, 0);
    applyStimulus("brc_taken",     0, 0, 0, 1, F_RUN|F_VALID|F_BJ|F_REL,  8'hFE, 9'h17E, 0, 0, 0);
    applyStimulus("flush_brc",     0, 0, 0, 1, F_RUN,                     8'h00, 9'h180, 0, 0, 0);
    applyStimulus("brc_nt_0x0F",   0, 0, 0, 0, F_RUN|F_VALID,             8'h00, 9'h145, 1, 3, 2);
    applyStimulus("brc_nt_0x10",   0, 0, 0, 0, F_RUN|F_VALID,             8'h00, 9'h17E, 1, 4, 2);
    applyStimulus("jmp_0x11",      0, 0, 0, 0, F_RUN|F_VALID|F_BJ,        8'hFF, 9'h180, 0, 0, 0);
    applyStimulus("flush_0x12",    0, 0, 0, 0, F_RUN,                     8'h00, 9'h012, 0, 0, 0);
    applyStimulus("jmp_0xFF",      0, 0, 0, 0, F_RUN|F_VALID|F_BJ,        8'h00, 9'h180, 0, 0, 0);
    applyStimulus("flush_stall",   0, 0, 1, 0, F_RUN,                     8'h00, 9'h180, 0, 0, 0);
    applyStimulus("stall1",        0, 0, 1, 0, F_HALT|F_VALID,            8'h00, 9'h180, 0, 0, 0);
    applyStimulus("stall2",        0, 1, 1, 0, F_HALT|F_VALID,            8'h00, 9'h180, 0, 0, 0);
    applyStimulus("stall3",        0, 0, 1, 0, F_HALT|F_VALID,            8'h00, 9'h180, 0, 0, 0);
    applyStimulus("jmp_unstall",   0, 0, 0, 0, F_RUN|F_VALID|F_BJ,        8'h20, 9'h180, 0, 0, 0);
    applyStimulus("flush_0x01",    0, 0, 0, 0, F_RUN,                     8'h00, 9'h001, 0, 0, 0);
    applyStimulus("hlt",           0, 0, 0, 0, F_HALT|F_VALID,            8'h00, 9'h1C0, 0, 0, 0);
    applyStimulus("halted_start",  0, 1, 0, 0, F_HALT|F_HALTED,           8'h00, 9'h1C0, 1, 9, 5);
    applyStimulus("halted",        0, 0, 0, 0, F_HALT|F_HALTED,           8'h00, 9'h1C0, 1, 9, 5);
    applyStimulus("reset_halted",  1, 0, 0, 0, F_RST,                     8'h00, 9'h1C0, 1, 0, 0);
    applyStimulus("idle_after",    0, 0, 0, 0, F_RST,                     8'h00, 9'h000, 1, 0, 0);

    begin
      int waitCycles;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
        @(posedge i_CLK);
        waitCycles++;
      end
      if (expQ.size() > 0) begin
        checkCount++;
        $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
      end
    end
    @(posedge i_CLK);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
